// File: rtl/displ_mux.sv
// Multiplexed seven-segment driver: scan, PWM, dead time, frame shadowing.
// Optional leading-zero blanking when DISPL_MUX_LZB_EN is defined.
module displ_mux #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1024,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dp,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [DIGITS-1:0]     dig,
  output logic [7:0]            seg,
  output logic                  frame
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [PW-1:0]         pre_cnt;
  logic [IW-1:0]         idx;
  logic                  loaded;
  logic [4*DIGITS-1:0]   number_s;
  logic [DIGITS-1:0]     dp_s;
  logic [BRIGHT_W-1:0]   bright_s;

  logic                  wrap;
  logic                  frame_end;
  logic                  lit;
  logic [BRIGHT_W-1:0]   phase;
  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  blank;
`ifdef DISPL_MUX_LZB_EN
  logic                  zero_hi;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  // Slot timing: wrap, frame end, PWM phase and dead-time gating
  always_comb begin
    wrap      = (pre_cnt == PRE_MAX);
    frame_end = en && wrap && (idx == IDX_MAX);
    phase     = pre_cnt[PW-1 -: BRIGHT_W];
    lit       = (phase <= bright_s) && (pre_cnt != '0);
  end

  // Select the active digit's nibble/dp and decide blanking
  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    blank  = 1'b0;
`ifdef DISPL_MUX_LZB_EN
    zero_hi = 1'b1;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef DISPL_MUX_LZB_EN
      zero_hi = zero_hi && (number_s[4*i +: 4] == 4'h0);
`endif
      if (idx == IW'(i)) begin
        nib    = number_s[4*i +: 4];
        dp_sel = dp_s[i];
`ifdef DISPL_MUX_LZB_EN
        blank  = zero_hi && (i != 0);
`endif
      end
    end
  end

  // Prescaler and digit index; both freeze while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      idx     <= '0;
    end else if (en) begin
      pre_cnt <= pre_cnt + PW'(1);
      if (wrap)
        idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end
  end

  // Shadow inputs on first enabled cycle and at every frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded   <= 1'b0;
      number_s <= '0;
      dp_s     <= '0;
      bright_s <= '0;
    end else if (en && (!loaded || frame_end)) begin
      loaded   <= 1'b1;
      number_s <= number;
      dp_s     <= dp;
      bright_s <= bright;
    end
  end

  // Registered pin drivers and frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig   <= '0;
      seg   <= '0;
      frame <= 1'b0;
    end else begin
      frame <= frame_end;
      if (en && lit) begin
        dig <= DIGITS'(1) << idx;
        seg <= {dp_sel, blank ? 7'h00 : hex7(nib)};
      end else begin
        dig <= '0;
        seg <= '0;
      end
    end
  end

endmodule
